// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches one 16-bit word per cycle into a
// one-entry valid/ready output slot, applies branch redirects and stops at the halt word.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] HALT_WORD  = 16'hFFFF,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        Start,
    output logic [15:0] IMemAddress,
    input  logic [15:0] IMemInstruction,
    output logic [15:0] Instr,
    output logic [15:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    output logic        Halted,
    output logic        Busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Byte-address span is a power of two, so wrapping is a simple mask.
    localparam int          PC_SPAN = 2 * IMEM_WORDS;
    localparam logic [15:0] PC_MASK = 16'(PC_SPAN - 1);

    logic [1:0]  state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic [15:0] instr_r, instr_s;
    logic [15:0] instr_pc_r, instr_pc_s;
    logic        valid_r, valid_s;
    logic        halted_r, halted_s;
    logic        busy_r;
    logic        slot_free_s;
    logic        handshake_s;
    logic [15:0] target_s;
    logic [15:0] pc_inc_s;

    assign slot_free_s = !valid_r || InstrReady;
    assign handshake_s = valid_r && InstrReady;
    assign target_s    = BranchTarget & 16'hFFFE & PC_MASK;
    assign pc_inc_s    = (pc_r + 16'd2) & PC_MASK;

    // Next-state decode; priority is Start, then redirect, then halt, then fetch.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        instr_s    = instr_r;
        instr_pc_s = instr_pc_r;
        valid_s    = valid_r;
        halted_s   = halted_r;
        if (Start) begin
            state_s  = ST_RUN;
            pc_s     = RESET_PC;
            valid_s  = 1'b0;
            halted_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (BranchTaken) begin
                        pc_s    = target_s;
                        valid_s = 1'b0;
                    end else if (IMemInstruction == HALT_WORD) begin
                        // A held entry survives the halt until decode takes it.
                        valid_s  = valid_r && !InstrReady;
                        halted_s = 1'b1;
                        state_s  = ST_HALTED;
                    end else if (slot_free_s) begin
                        instr_s    = IMemInstruction;
                        instr_pc_s = pc_r;
                        valid_s    = 1'b1;
                        pc_s       = pc_inc_s;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                ST_HALTED: begin
                    if (handshake_s) begin
                        valid_s = 1'b0;
                    end else begin
                        valid_s = valid_r;
                    end
                end
                ST_IDLE: begin
                    valid_s = 1'b0;
                end
                default: begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, PC and output slot registers.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            instr_r    <= 16'h0000;
            instr_pc_r <= 16'h0000;
            valid_r    <= 1'b0;
            halted_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            instr_r    <= instr_s;
            instr_pc_r <= instr_pc_s;
            valid_r    <= valid_s;
            halted_r   <= halted_s;
            busy_r     <= (state_s == ST_RUN);
        end
    end

    assign IMemAddress = pc_r;
    assign Instr       = instr_r;
    assign InstrPC     = instr_pc_r;
    assign InstrValid  = valid_r;
    assign Halted      = halted_r;
    assign Busy        = busy_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed program scenarios with literal
// expectations, then randomized stimulus checked every cycle against a behavioural model.
module tb_fetch_sequencer;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic        Start;
    logic [15:0] IMemAddress;
    logic [15:0] IMemInstruction;
    logic [15:0] Instr;
    logic [15:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic        Halted;
    logic        Busy;

    logic [15:0] mem [0:1023];
    logic [15:0] prog [0:9];

    int checks = 0;
    int errors = 0;

    // Model of the sequencer: mode 0 idle, 1 running, 2 halted.
    int          m_mode;
    int          m_pc;
    logic [15:0] m_instr;
    int          m_ipc;
    logic        m_valid;
    logic        m_halted;

    always #5 Clock = ~Clock;

    assign IMemInstruction = mem[IMemAddress[10:1]];

    fetch_sequencer dut (
        .Clock           (Clock),
        .ResetN          (ResetN),
        .Start           (Start),
        .IMemAddress     (IMemAddress),
        .IMemInstruction (IMemInstruction),
        .Instr           (Instr),
        .InstrPC         (InstrPC),
        .InstrValid      (InstrValid),
        .InstrReady      (InstrReady),
        .BranchTaken     (BranchTaken),
        .BranchTarget    (BranchTarget),
        .Halted          (Halted),
        .Busy            (Busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_pc     = 0;
        m_instr  = 16'h0000;
        m_ipc    = 0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        w = mem[m_pc / 2];
        if (Start) begin
            m_mode   = 1;
            m_pc     = 0;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (m_mode == 1) begin
            if (BranchTaken) begin
                m_pc    = (int'(BranchTarget) / 2 * 2) % 2048;
                m_valid = 1'b0;
            end else if (w == 16'hFFFF) begin
                if (m_valid && InstrReady) m_valid = 1'b0;
                m_halted = 1'b1;
                m_mode   = 2;
            end else if (!m_valid || InstrReady) begin
                m_instr = w;
                m_ipc   = m_pc;
                m_valid = 1'b1;
                m_pc    = (m_pc + 2) % 2048;
            end
        end else if (m_mode == 2) begin
            if (m_valid && InstrReady) m_valid = 1'b0;
        end
    endtask

    // Model advances on the same edge as the DUT; reset is level and edge sensitive.
    always @(posedge Clock) begin
        if (!ResetN) model_reset();
        else model_step();
    end

    always @(negedge ResetN) model_reset();

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        chk("addr",   IMemAddress, 16'(m_pc));
        chk("instr",  Instr,       m_instr);
        chk("ipc",    InstrPC,     16'(m_ipc));
        chk("valid",  16'(InstrValid), 16'(m_valid));
        chk("halted", 16'(Halted),     16'(m_halted));
        chk("busy",   16'(Busy),       16'(m_mode == 1));
    end

    // Apply inputs, then let one active edge pass; returns 2 time units after it.
    task automatic step(input logic s, input logic r, input logic b, input logic [15:0] t);
        Start        = s;
        InstrReady   = r;
        BranchTaken  = b;
        BranchTarget = t;
        @(posedge Clock);
        #2;
    endtask

    task automatic load_default();
        prog[0] = 16'h710F; prog[1] = 16'h7207; prog[2] = 16'h26C0; prog[3] = 16'h3A11;
        prog[4] = 16'h0AF0; prog[5] = 16'h5C22; prog[6] = 16'h4D33; prog[7] = 16'h1E44;
        prog[8] = 16'h6B40; prog[9] = 16'hFFFF;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0100 ^ 16'(i);
        for (int i = 0; i < 10; i++) mem[i] = prog[i];
    endtask

    initial begin
        load_default();
        model_reset();
        ResetN = 1'b0;
        Start = 1'b0; InstrReady = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000;
        @(posedge Clock); #2;
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("rst_valid", 16'(InstrValid), 16'h0000);
        chk("rst_addr",  IMemAddress,     16'h0000);
        ResetN = 1'b1;
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("idle_busy", 16'(Busy), 16'h0000);

        // Full-throughput run to the halt word.
        step(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("start_busy", 16'(Busy), 16'h0001);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000);
            chk("seq_instr", Instr,   prog[i]);
            chk("seq_ipc",   InstrPC, 16'(2 * i));
        end
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("seq_halted", 16'(Halted),     16'h0001);
        chk("seq_valid",  16'(InstrValid), 16'h0000);

        // Back-pressure on the first instruction.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("bp_instr", Instr,       16'h710F);
        chk("bp_ipc",   InstrPC,     16'h0000);
        chk("bp_addr",  IMemAddress, 16'h0002);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("bp_next",  Instr,       16'h7207);

        // Redirect while the PC 4 entry is held.
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("br_held", Instr, 16'h26C0);
        step(1'b0, 1'b0, 1'b1, 16'h0009);
        chk("br_flush", 16'(InstrValid), 16'h0000);
        chk("br_addr",  IMemAddress,     16'h0008);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("br_instr", Instr,   16'h0AF0);
        chk("br_ipc",   InstrPC, 16'h0008);

        // Halt under back-pressure.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("hb_last", Instr, 16'h6B40);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("hb_halted", 16'(Halted),     16'h0001);
        chk("hb_valid",  16'(InstrValid), 16'h0001);
        chk("hb_instr",  Instr,           16'h6B40);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("hb_drain",  16'(InstrValid), 16'h0000);

        // Restart from HALTED, then restart mid-run.
        step(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("rs_halted", 16'(Halted), 16'h0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("rs_instr", Instr, 16'h26C0);
        step(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("rs_addr", IMemAddress, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("rs_first", Instr, 16'h710F);

        // PC wrap at the top of memory, then an asynchronous reset between edges.
        step(1'b0, 1'b1, 1'b1, 16'h07FE);
        chk("wr_addr", IMemAddress, 16'h07FE);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("wr_instr", Instr,       16'h0100 ^ 16'd1023);
        chk("wr_next",  IMemAddress, 16'h0000);
        #1 ResetN = 1'b0;
        #1;
        chk("ar_valid", 16'(InstrValid), 16'h0000);
        chk("ar_instr", Instr,           16'h0000);
        chk("ar_busy",  16'(Busy),       16'h0000);
        @(negedge Clock); #1 ResetN = 1'b1;
        @(posedge Clock); #2;

        // Randomized traffic over a random image with sparse halt words.
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                #1 ResetN = 1'b0;
                #1 ResetN = 1'b1;
            end
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
